// File: rtl/alu_mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_mult_seq_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   - FSM state encoding (IDLE / RUN / DONE; 2'b11 is unused)
//   - select codes for the shared arithmetic unit
//   - iteration count and counter width for the RUN phase
// -----------------------------------------------------------------------------
package alu_mult_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Arithmetic unit operation selects
    localparam logic [1:0] ALU_SEL_ADD = 2'b00;  // a + b + cin
    localparam logic [1:0] ALU_SEL_SUB = 2'b01;  // a + ~b + cin (cin=1 for plain a-b)
    localparam logic [1:0] ALU_SEL_INC = 2'b10;  // a + 1
    localparam logic [1:0] ALU_SEL_DEC = 2'b11;  // a - 1

    // One RUN cycle per multiplier bit
    localparam int ITER_COUNT = 8;
    localparam int CNT_W      = $clog2(ITER_COUNT);

endpackage : alu_mult_seq_pkg

// File: rtl/alu_mult_seq_alu_arithmetic.sv
// -----------------------------------------------------------------------------
// ALU_Arithmetic
// Combinational arithmetic unit built around a single WIDTH-bit adder.
//   a, b      : operands
//   sel       : operation select (see alu_mult_seq_pkg ALU_SEL_*)
//   cin       : carry-in (used by ADD and SUB only)
//   result    : WIDTH-bit result
//   cout      : adder carry-out
//   negative  : result MSB
//   overflow  : signed overflow of the adder
// -----------------------------------------------------------------------------
module ALU_Arithmetic
    import alu_mult_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             negative,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [WIDTH:0]   sum_ext;

    // Every operation is mapped onto one adder by choosing the second
    // operand and the carry-in.
    always_comb begin
        b_eff   = b;
        cin_eff = cin;
        case (sel)
            ALU_SEL_ADD: begin
                b_eff   = b;
                cin_eff = cin;
            end
            ALU_SEL_SUB: begin
                b_eff   = ~b;
                cin_eff = cin;
            end
            ALU_SEL_INC: begin
                b_eff   = '0;
                cin_eff = 1'b1;
            end
            ALU_SEL_DEC: begin
                b_eff   = '1;
                cin_eff = 1'b0;
            end
            default: begin
                b_eff   = b;
                cin_eff = cin;
            end
        endcase
    end

    assign sum_ext  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
    assign result   = sum_ext[WIDTH-1:0];
    assign cout     = sum_ext[WIDTH];
    assign negative = sum_ext[WIDTH-1];
    // Signed overflow: operands agree in sign but the result does not
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                      (sum_ext[WIDTH-1] != a[WIDTH-1]);

endmodule : ALU_Arithmetic

// File: rtl/alu_mult_seq.sv
// -----------------------------------------------------------------------------
// alu_mult_seq
// Sequential unsigned shift-and-add multiplier, one multiplier bit per cycle.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   Start    : begin a multiply (only looked at in IDLE)
//   A        : multiplicand, captured on an accepted Start
//   B        : multiplier, captured on an accepted Start
//   Busy     : high while RUN or DONE
//   Done     : one-cycle pulse, Product valid in that cycle
//   Product  : registered A*B, held until the next accepted Start completes
//
// Accumulator P starts as {0, B}. Each RUN cycle conditionally adds M to the
// upper half and shifts the whole {carry, upper, lower} right by one, so the
// multiplier bits are consumed from P[0] while the product grows from the top.
// -----------------------------------------------------------------------------
module alu_mult_seq
    import alu_mult_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic [WIDTH-1:0]     alu_sum;
    logic                 alu_cout;
    logic                 alu_neg_unused;
    logic                 alu_ovf_unused;
    logic [2*WIDTH-1:0]   p_step;

    // -------------------------------------------------------------------------
    // Shared adder: upper half of P plus M when the current multiplier bit is
    // set, plus zero otherwise (which passes the upper half through with C=0).
    // -------------------------------------------------------------------------
    assign alu_a = p_q[2*WIDTH-1:WIDTH];
    assign alu_b = p_q[0] ? m_q : '0;

    ALU_Arithmetic #(
        .WIDTH    (WIDTH)
    ) u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .sel      (ALU_SEL_ADD),
        .cin      (1'b0),
        .result   (alu_sum),
        .cout     (alu_cout),
        .negative (alu_neg_unused),
        .overflow (alu_ovf_unused)
    );

    // Carry-out lands in the MSB so no product bit is lost on 0xFF*0xFF.
    assign p_step = {alu_cout, alu_sum, p_q[WIDTH-1:1]};

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (Start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            // Encoding 2'b11 is unreachable; recover to IDLE if it ever appears
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state_q)
            ST_RUN:  Busy = 1'b1;
            ST_DONE: begin
                Busy = 1'b1;
                Done = 1'b1;
            end
            default: begin
                Busy = 1'b0;
                Done = 1'b0;
            end
        endcase
    end

    assign Product = product_q;

    // -------------------------------------------------------------------------
    // Datapath next-state: operand capture, shift/add step, iteration count
    // and the product register (loaded only on the last RUN cycle).
    // -------------------------------------------------------------------------
    always_comb begin
        m_d       = m_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    m_d   = A;
                    p_d   = {{WIDTH{1'b0}}, B};
                    cnt_d = '0;
                end
            end
            ST_RUN: begin
                p_d   = p_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    product_d = p_step;
                end
            end
            default: begin
                m_d       = m_q;
                p_d       = p_q;
                cnt_d     = cnt_q;
                product_d = product_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            m_q       <= '0;
            p_q       <= '0;
            product_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            p_q       <= p_d;
            product_q <= product_d;
        end
    end

endmodule : alu_mult_seq

// File: tb/tb_alu_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_mult_seq
// Directed scenarios plus randomized multiplies against a cycle-level
// behavioural model (countdown of remaining busy cycles, product = A*B).
// -----------------------------------------------------------------------------
module tb_alu_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        Busy;
    logic        Done;
    logic [15:0] Product;

    always #5 clk = ~clk;

    alu_mult_seq #(
        .WIDTH   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .Product (Product)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model. An accepted Start begins 9 busy cycles; the last of
    // them is the Done cycle, where the product A*B becomes visible and stays
    // until the next completed operation.
    // -------------------------------------------------------------------------
    int          mdl_cnt     = 0;
    logic [15:0] mdl_pending = 16'h0;
    logic [15:0] mdl_prod    = 16'h0;
    bit          chk_en      = 1'b0;
    int          cyc         = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mdl_cnt     = 0;
            mdl_pending = 16'h0;
            mdl_prod    = 16'h0;
            chk_en      = 1'b1;
        end else if (mdl_cnt == 0) begin
            if (Start) begin
                mdl_pending = 16'(A) * 16'(B);
                mdl_cnt     = 9;
            end
        end else begin
            mdl_cnt--;
            if (mdl_cnt == 1) mdl_prod = mdl_pending;
        end
    end

    // Per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'b0, Busy}, {31'b0, (mdl_cnt > 0)});
            check("done", {31'b0, Done}, {31'b0, (mdl_cnt == 1)});
            check("product", {16'b0, Product}, {16'b0, mdl_prod});
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (all called at a negedge)
    // -------------------------------------------------------------------------
    task automatic wait_idle();
        int g;
        g = 0;
        while (mdl_cnt != 0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        Start = 1'b1;
        A     = a;
        B     = b;
        @(negedge clk);
        Start = 1'b0;
    endtask

    // lat counts negedges after the accepting edge until Done is seen
    task automatic wait_done(input bit scramble, output int lat);
        lat = 1;
        while (Done !== 1'b1 && lat < 20) begin
            if (scramble) begin
                Start = 1'($urandom);
                A     = 8'($urandom);
                B     = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        Start = 1'b0;
        if (Done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit scramble,
                         output logic [15:0] prod, output int lat);
        wait_idle();
        start_op(a, b);
        wait_done(scramble, lat);
        prod = Product;
        $display("op A=%02h B=%02h product=%04h latency=%0d cycle=%0d", a, b, prod, lat, cyc);
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (Done === 1'b1) cnt++;
        end
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    initial begin
        logic [15:0] p, p1, p2;
        int          lat, extra, c1, c2, gap;
        logic [7:0]  ra, rb;

        rst   = 1'b1;
        Start = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, Busy}, 32'd0);
        check("reset_done", {31'b0, Done}, 32'd0);
        check("reset_product", {16'b0, Product}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic latency and value
        do_op(8'h0F, 8'h11, 1'b0, p, lat);
        check("p_0f_11", {16'b0, p}, 32'h00FF);
        check("lat_0f_11", lat, 32'd9);

        // Full range
        do_op(8'hFF, 8'hFF, 1'b0, p, lat);
        check("p_ff_ff", {16'b0, p}, 32'hFE01);
        do_op(8'h00, 8'hFF, 1'b0, p, lat);
        check("p_00_ff", {16'b0, p}, 32'h0000);

        // Start and operand changes during RUN are ignored
        wait_idle();
        start_op(8'd3, 8'd5);
        Start = 1'b1;
        A     = 8'hAA;
        B     = 8'h55;
        wait_done(1'b0, lat);
        check("p_3_5_ignore", {16'b0, Product}, 32'h000F);
        check("lat_3_5", lat, 32'd9);
        $display("op A=03 B=05 product=%04h latency=%0d cycle=%0d", Product, lat, cyc);
        count_dones(12, extra);
        check("no_second_op", extra, 32'd0);
        check("idle_after_ignore", {31'b0, Busy}, 32'd0);

        // Reset in the middle of RUN (counter = 4)
        wait_idle();
        start_op(8'd7, 8'd9);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'b0, Busy}, 32'd0);
        check("abort_product", {16'b0, Product}, 32'h0000);
        $display("op A=07 B=09 aborted by reset cycle=%0d", cyc);
        count_dones(12, extra);
        check("abort_no_done", extra, 32'd0);
        do_op(8'd2, 8'd2, 1'b0, p, lat);
        check("p_2_2", {16'b0, p}, 32'h0004);
        check("lat_2_2", lat, 32'd9);

        // Back-to-back
        do_op(8'h10, 8'h10, 1'b0, p1, lat);
        c1 = cyc;
        do_op(8'h80, 8'h02, 1'b0, p2, lat);
        c2 = cyc;
        check("p_10_10", {16'b0, p1}, 32'h0100);
        check("p_80_02", {16'b0, p2}, 32'h0100);
        check("b2b_spacing", c2 - c1, 32'd10);

        // Random operands, random gaps, random noise on inputs while busy
        for (int i = 0; i < 1000; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_op(ra, rb, 1'b1, p, lat);
            check("rand_product", {16'b0, p}, {16'b0, 16'(ra) * 16'(rb)});
            check("rand_latency", lat, 32'd9);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_alu_mult_seq
